frame_builder: RTL and testbench

Transmit-side framer for the 13-byte command frame consumed by the receive-side parser. It accepts a 64-bit payload with a start pulse and emits the frame bytes in order to the UART transmitter over a valid/ready byte handshake: header, length, command, 8 data bytes, checksum, tail. It sits between the host logic that produces payloads and the UART TX serializer.

---
 rtl/frame_defs.sv | 33 +++
 rtl/frame_builder.sv | 118 +++++++++++
 tb/tb_frame_builder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_defs.sv
// Shared frame definitions for the transmit framer and the receive parser.
// Both ends import these constants so the frame format cannot drift apart.
package frame_defs;

  localparam logic [7:0] HEADER_DEFAULT = 8'h52;
  localparam logic [7:0] LEN_DEFAULT    = 8'h0D;
  localparam logic [7:0] CMD_DEFAULT    = 8'h01;
  localparam logic [7:0] TAIL_DEFAULT   = 8'h9A;

  localparam int DATA_BYTES = 8;
  localparam int FRAME_LEN  = 13;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LENGTH,
    CMD,
    DATA,
    CHECK,
    TAIL
  } state_t;

  // Constant part of the check byte: whatever the fixed bytes leave over
  // from FF. The check byte is this value minus the data sum, so that all
  // 13 bytes add up to FF modulo 256.
  function automatic logic [7:0] check_base(input logic [7:0] hdr,
                                            input logic [7:0] len,
                                            input logic [7:0] cmd,
                                            input logic [7:0] tail);
    return 8'hFF - hdr - len - cmd - tail;
  endfunction

endpackage

// File: rtl/frame_builder.sv
// Transmit-side framer: turns a 64-bit payload into the 13-byte command
// frame (header, length, command, 8 data bytes, checksum, tail) over a
// valid/ready byte stream. All outputs come straight from registers.
module frame_builder
  import frame_defs::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_DEFAULT,
  parameter logic [7:0] LEN_BYTE    = LEN_DEFAULT,
  parameter logic [7:0] CMD_BYTE    = CMD_DEFAULT,
  parameter logic [7:0] TAIL_BYTE   = TAIL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] payload,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] CHECK_BASE = check_base(HEADER_BYTE, LEN_BYTE, CMD_BYTE, TAIL_BYTE);
  localparam logic [2:0] LAST_IDX   = 3'(DATA_BYTES - 1);

  state_t      state_reg, state_next;
  logic [63:0] shift_reg, shift_next;
  logic [7:0]  sum_reg, sum_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        tx_valid_reg;
  logic        busy_reg;
  logic        done_reg, done_next;
  logic        xfer;

  // Next-state, datapath updates and the byte to present next cycle.
  // The outgoing byte is derived from the *next* state so tx_data can be
  // registered and still line up with tx_valid; with no transfer nothing
  // changes, which keeps the byte held during a stall.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    sum_next     = sum_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    tx_data_next = 8'h00;
    xfer         = tx_valid_reg && tx_ready;

    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next = payload;
          sum_next   = 8'h00;
          cnt_next   = 3'd0;
          state_next = HEADER;
        end
      end
      HEADER: if (xfer) state_next = LENGTH;
      LENGTH: if (xfer) state_next = CMD;
      CMD:    if (xfer) state_next = DATA;
      DATA: begin
        if (xfer) begin
          shift_next = {shift_reg[55:0], 8'h00};
          sum_next   = sum_reg + shift_reg[63:56];
          cnt_next   = cnt_reg + 3'd1;
          if (cnt_reg == LAST_IDX) state_next = CHECK;
        end
      end
      CHECK:  if (xfer) state_next = TAIL;
      TAIL: begin
        if (xfer) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    case (state_next)
      HEADER:  tx_data_next = HEADER_BYTE;
      LENGTH:  tx_data_next = LEN_BYTE;
      CMD:     tx_data_next = CMD_BYTE;
      DATA:    tx_data_next = shift_next[63:56];
      CHECK:   tx_data_next = CHECK_BASE - sum_next;
      TAIL:    tx_data_next = TAIL_BYTE;
      default: tx_data_next = 8'h00;
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= 64'h0;
      sum_reg      <= 8'h00;
      cnt_reg      <= 3'd0;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      sum_reg      <= sum_next;
      cnt_reg      <= cnt_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= (state_next != IDLE);
      busy_reg     <= (state_next != IDLE);
      done_reg     <= done_next;
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder: directed frames, random payloads
// with random ready stalls, ignored mid-frame start, back-to-back frames
// and reset mid-frame, all checked against a byte-list model of the frame.
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] payload = 64'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int done_cnt;
  int first_valid_cyc;
  int end_cyc;

  always #5 clk = ~clk;

  frame_builder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .payload  (payload),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: the fixed bytes, the payload MSB first, then whatever
  // byte makes the whole frame sum to FF, then the tail.
  function automatic void build_expected(input logic [63:0] p);
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 8; i++) exp_q.push_back(p[63-8*i -: 8]);
    s = 8'h9A;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_back(8'hFF - s);
    exp_q.push_back(8'h9A);
  endfunction

  // Watch the byte stream until n_bytes have transferred, applying random
  // per-byte stalls and checking hold-stability and busy==tx_valid.
  task automatic collect(input int n_bytes, input int stall_max,
                         input bit inject, input logic [63:0] inj_payload);
    int cyc = 0;
    int stall_left = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    got.delete();
    done_cnt = 0;
    first_valid_cyc = -1;
    while (got.size() < n_bytes && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = inject && (got.size() == 5);
      if (start) payload = inj_payload;
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      check("busy_eq_valid", busy, tx_valid);
      if (done) done_cnt++;
      if (tx_valid && !prev_stall)
        stall_left = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      tx_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
    end_cyc = cyc;
    check("collect_timeout", got.size() >= n_bytes, 1);
  endtask

  task automatic compare_frame(input string tag, input logic [63:0] p);
    logic [7:0] s = 8'h00;
    build_expected(p);
    check({tag, "_len"}, got.size(), 13);
    for (int i = 0; i < 13 && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
    foreach (got[i]) s = s + got[i];
    check({tag, "_sum"}, s, 8'hFF);
    check({tag, "_no_early_done"}, done_cnt, 0);
    $display("frame %s payload=%016h bytes=%p", tag, p, got);
  endtask

  // Called on the negedge right after the tail transfer.
  task automatic finish_frame(input string tag);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_idle_valid"}, tx_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    @(negedge clk);
    check({tag, "_done_once"}, done, 0);
  endtask

  initial begin
    logic [63:0] p;
    logic [63:0] p2;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    check("idle_valid", tx_valid, 0);

    // Directed frame, no stalls: exact cycle timing and known check byte
    p = 64'h0102030405060708;
    start = 1'b1; payload = p;
    collect(13, 0, 0, 64'h0);
    compare_frame("t1", p);
    check("t1_first_cyc", first_valid_cyc, 1);
    check("t1_last_cyc", end_cyc, 13);
    if (got.size() > 11) check("t1_chk_E1", got[11], 8'hE1);
    finish_frame("t1");

    // All-zero and all-ones payloads
    p = 64'h0;
    start = 1'b1; payload = p;
    collect(13, 0, 0, 64'h0);
    compare_frame("t2", p);
    if (got.size() > 11) check("t2_chk_05", got[11], 8'h05);
    finish_frame("t2");

    p = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1; payload = p;
    collect(13, 0, 0, 64'h0);
    compare_frame("t3", p);
    if (got.size() > 11) check("t3_chk_0D", got[11], 8'h0D);
    finish_frame("t3");

    // Random payloads under random stalls (0-5 cycles per byte)
    for (int k = 0; k < 4; k++) begin
      p = {$urandom, $urandom};
      start = 1'b1; payload = p;
      collect(13, 5, 0, 64'h0);
      compare_frame($sformatf("rnd%0d", k), p);
      finish_frame($sformatf("rnd%0d", k));
    end

    // Same directed payload with stalls must give the same bytes
    p = 64'h0102030405060708;
    start = 1'b1; payload = p;
    collect(13, 5, 0, 64'h0);
    compare_frame("t1_stall", p);
    finish_frame("t1_stall");

    // start with a different payload during DATA is ignored
    p = 64'hDEAD_BEEF_0BAD_F00D;
    start = 1'b1; payload = p;
    collect(13, 2, 1, 64'h1111_2222_3333_4444);
    compare_frame("ignore", p);
    finish_frame("ignore");

    // Back-to-back: new start accepted in the done cycle
    p  = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    start = 1'b1; payload = p;
    collect(13, 0, 0, 64'h0);
    compare_frame("b2b_a", p);
    @(negedge clk);
    check("b2b_done", done, 1);
    start = 1'b1; payload = p2;
    collect(13, 0, 0, 64'h0);
    check("b2b_first_cyc", first_valid_cyc, 1);
    compare_frame("b2b_b", p2);
    finish_frame("b2b_b");

    // Reset while DATA byte 4 is on the bus, then a clean frame
    p = 64'hA1B2_C3D4_E5F6_0718;
    start = 1'b1; payload = p;
    collect(6, 0, 0, 64'h0);
    @(negedge clk);
    check("rst_mid_byte4", tx_data, p[39:32]);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_after_done", done, 0);
      check("rst_after_valid", tx_valid, 0);
    end
    p = {$urandom, $urandom};
    start = 1'b1; payload = p;
    collect(13, 3, 0, 64'h0);
    compare_frame("post_rst", p);
    finish_frame("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
